// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans voices one per cycle, then retriggers, assigns or steals a voice.
// Optional feature macro: VOICE_ALLOC_STEAL_EN enables stealing the oldest voice when all are busy.
module voice_allocator #(
  parameter int NUM_OSCILLATORS = 4,
  parameter int RATE_WIDTH      = 24
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  valid_in,
  input  logic                                  is_note_on_in,
  input  logic [6:0]                            note_in,
  input  logic [RATE_WIDTH-1:0]                 rate_in,
  output logic                                  ready_out,
  output logic [NUM_OSCILLATORS-1:0]            is_on_out,
  output logic [NUM_OSCILLATORS*RATE_WIDTH-1:0] playback_rate_out,
  output logic                                  steal_out,
  output logic [7:0]                            drop_count_out
);

  localparam int AW = $clog2(NUM_OSCILLATORS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_OSCILLATORS - 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]                 r_state;
  logic [AW-1:0]              r_idx;
  logic                       r_ev_on;
  logic [6:0]                 r_ev_note;
  logic [RATE_WIDTH-1:0]      r_ev_rate;
  logic                       r_match_vld;
  logic [AW-1:0]              r_match_idx;
  logic                       r_free_vld;
  logic [AW-1:0]              r_free_idx;
  logic [NUM_OSCILLATORS-1:0] r_on;
  logic [6:0]                 r_note [NUM_OSCILLATORS];
  logic [RATE_WIDTH-1:0]      r_rate [NUM_OSCILLATORS];
  logic [AW-1:0]              r_age  [NUM_OSCILLATORS];
  logic [7:0]                 r_drop;

  logic          w_rate_zero;
  logic          w_accept;
  logic          w_early_drop;
  logic          w_sel_vld;
  logic [AW-1:0] w_sel_idx;
  logic          w_off_vld;
  logic          w_commit_drop;
  logic [1:0]    w_drop_inc;
  logic [8:0]    w_drop_sum;
  logic [7:0]    w_drop_next;

`ifdef VOICE_ALLOC_STEAL_EN
  logic          r_old_vld;
  logic [AW-1:0] r_old_idx;
  logic [AW-1:0] r_old_age;
  logic          r_steal;
  logic          w_steal;
`endif

  // A note-on with zero rate is rejected at the door, as is anything arriving while busy
  assign w_rate_zero  = (rate_in == {RATE_WIDTH{1'b0}});
  assign w_accept     = (r_state == S_IDLE) && valid_in && !(is_note_on_in && w_rate_zero);
  assign w_early_drop = valid_in && ((r_state != S_IDLE) || (is_note_on_in && w_rate_zero));
  assign w_drop_inc   = {1'b0, w_early_drop} + {1'b0, w_commit_drop};
  assign w_drop_sum   = {1'b0, r_drop} + {7'd0, w_drop_inc};

  // Saturating drop counter next value
  always_comb begin
    w_drop_next = w_drop_sum[7:0];
    if (w_drop_sum[8]) begin
      w_drop_next = 8'hFF;
    end else begin
      w_drop_next = w_drop_sum[7:0];
    end
  end

  // Commit decision: retrigger, then lowest free voice, then oldest (or drop)
  always_comb begin
    w_sel_vld     = 1'b0;
    w_sel_idx     = {AW{1'b0}};
    w_off_vld     = 1'b0;
    w_commit_drop = 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
    w_steal       = 1'b0;
`endif
    if (r_state == S_COMMIT) begin
      if (r_ev_on) begin
        if (r_match_vld) begin
          w_sel_vld = 1'b1;
          w_sel_idx = r_match_idx;
        end else if (r_free_vld) begin
          w_sel_vld = 1'b1;
          w_sel_idx = r_free_idx;
        end else begin
`ifdef VOICE_ALLOC_STEAL_EN
          if (r_old_vld) begin
            w_sel_vld = 1'b1;
            w_sel_idx = r_old_idx;
            w_steal   = 1'b1;
          end else begin
            w_commit_drop = 1'b1;
          end
`else
          w_commit_drop = 1'b1;
`endif
        end
      end else begin
        w_off_vld = r_match_vld;
      end
    end else begin
      w_sel_vld = 1'b0;
    end
  end

  // Control FSM and per-cycle voice scan
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_idx       <= {AW{1'b0}};
      r_ev_on     <= 1'b0;
      r_ev_note   <= 7'd0;
      r_ev_rate   <= {RATE_WIDTH{1'b0}};
      r_match_vld <= 1'b0;
      r_match_idx <= {AW{1'b0}};
      r_free_vld  <= 1'b0;
      r_free_idx  <= {AW{1'b0}};
`ifdef VOICE_ALLOC_STEAL_EN
      r_old_vld   <= 1'b0;
      r_old_idx   <= {AW{1'b0}};
      r_old_age   <= {AW{1'b0}};
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ev_on     <= is_note_on_in;
            r_ev_note   <= note_in;
            r_ev_rate   <= rate_in;
            r_idx       <= {AW{1'b0}};
            r_match_vld <= 1'b0;
            r_free_vld  <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
            r_old_vld   <= 1'b0;
`endif
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_on[r_idx] && (r_note[r_idx] == r_ev_note) && !r_match_vld) begin
            r_match_vld <= 1'b1;
            r_match_idx <= r_idx;
          end
          if (!r_on[r_idx] && !r_free_vld) begin
            r_free_vld <= 1'b1;
            r_free_idx <= r_idx;
          end
`ifdef VOICE_ALLOC_STEAL_EN
          if (r_on[r_idx] && (!r_old_vld || (r_age[r_idx] > r_old_age))) begin
            r_old_vld <= 1'b1;
            r_old_idx <= r_idx;
            r_old_age <= r_age[r_idx];
          end
`endif
          if (r_idx == LAST_IDX) begin
            r_state <= S_COMMIT;
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        S_COMMIT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Voice table, age ordering and drop counter
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_on   <= {NUM_OSCILLATORS{1'b0}};
      r_drop <= 8'd0;
      for (int i = 0; i < NUM_OSCILLATORS; i++) begin
        r_note[i] <= 7'd0;
        r_rate[i] <= {RATE_WIDTH{1'b0}};
        r_age[i]  <= AW'(i);
      end
    end else begin
      r_drop <= w_drop_next;
      if (w_sel_vld) begin
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
          if (AW'(i) == w_sel_idx) begin
            r_on[i]   <= 1'b1;
            r_note[i] <= r_ev_note;
            r_rate[i] <= r_ev_rate;
            r_age[i]  <= {AW{1'b0}};
          end else if (r_age[i] < r_age[w_sel_idx]) begin
            r_age[i] <= r_age[i] + AW'(1);
          end
        end
      end else if (w_off_vld) begin
        r_on[r_match_idx] <= 1'b0;
      end
    end
  end

`ifdef VOICE_ALLOC_STEAL_EN
  // One-cycle steal pulse aligned with the commit edge
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_steal <= 1'b0;
    end else begin
      r_steal <= w_steal;
    end
  end
  assign steal_out = r_steal;
`else
  assign steal_out = 1'b0;
`endif

  assign ready_out      = (r_state == S_IDLE);
  assign is_on_out      = r_on;
  assign drop_count_out = r_drop;

  for (genvar g = 0; g < NUM_OSCILLATORS; g++) begin : g_rate_out
    assign playback_rate_out[g*RATE_WIDTH +: RATE_WIDTH] = r_rate[g];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random events against an LRU-list model.
module tb_voice_allocator;
  localparam int N  = 4;
  localparam int RW = 24;

  logic            clk = 1'b0;
  logic            rst_in;
  logic            valid_in;
  logic            is_note_on_in;
  logic [6:0]      note_in;
  logic [RW-1:0]   rate_in;
  logic            ready_out;
  logic [N-1:0]    is_on_out;
  logic [N*RW-1:0] playback_rate_out;
  logic            steal_out;
  logic [7:0]      drop_count_out;

  int checks = 0;
  int failures = 0;
  int steal_seen = 0;

  logic          m_on   [N];
  logic [6:0]    m_note [N];
  logic [RW-1:0] m_rate [N];
  int            m_drop;
  int            lru [$];

  voice_allocator #(.NUM_OSCILLATORS(N), .RATE_WIDTH(RW)) dut (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .is_note_on_in(is_note_on_in),
    .note_in(note_in), .rate_in(rate_in), .ready_out(ready_out), .is_on_out(is_on_out),
    .playback_rate_out(playback_rate_out), .steal_out(steal_out), .drop_count_out(drop_count_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (steal_out === 1'b1) steal_seen++;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_on[i] = 1'b0; m_note[i] = 7'd0; m_rate[i] = '0;
    end
    lru.delete();
    for (int i = 0; i < N; i++) lru.push_back(i);
    m_drop = 0;
  endtask

  // lru[0] is the most recently assigned voice, lru[$] the oldest
  task automatic model_event(input logic on, input logic [6:0] n, input logic [RW-1:0] r,
                             input int junk, output int exp_steal);
    int sel, k;
    exp_steal = 0; sel = -1; k = junk;
    if (on && r == '0) begin
      k++;
    end else if (on) begin
      for (int i = 0; i < N; i++) if (sel < 0 && m_on[i] && m_note[i] == n) sel = i;
      for (int i = 0; i < N; i++) if (sel < 0 && !m_on[i]) sel = i;
      if (sel < 0) begin
`ifdef VOICE_ALLOC_STEAL_EN
        sel = lru[$];
        exp_steal = 1;
`else
        k++;
`endif
      end
      if (sel >= 0) begin
        m_on[sel] = 1'b1; m_note[sel] = n; m_rate[sel] = r;
        for (int p = 0; p < lru.size(); p++) if (lru[p] == sel) begin lru.delete(p); break; end
        lru.push_front(sel);
      end
    end else begin
      for (int i = 0; i < N; i++) if (sel < 0 && m_on[i] && m_note[i] == n) sel = i;
      if (sel >= 0) m_on[sel] = 1'b0;
    end
    m_drop = (m_drop + k > 255) ? 255 : m_drop + k;
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_on;
    logic [7:0] e_drop;
    for (int i = 0; i < N; i++) e_on[i] = m_on[i];
    e_drop = m_drop[7:0];
    check_val("is_on", is_on_out, e_on);
    for (int i = 0; i < N; i++) check_val($sformatf("rate%0d", i), playback_rate_out[i*RW +: RW], m_rate[i]);
    check_val("drop", drop_count_out, e_drop);
    check_val("ready", ready_out, 1'b1);
  endtask

  task automatic check_reset_state();
    check_val("rst_ready", ready_out, 1'b1);
    check_val("rst_is_on", is_on_out, {N{1'b0}});
    check_val("rst_rates", playback_rate_out, {N*RW{1'b0}});
    check_val("rst_steal", steal_out, 1'b0);
    check_val("rst_drop", drop_count_out, 8'd0);
  endtask

  task automatic apply_reset();
    rst_in = 1'b0; valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
    m_reset();
  endtask

  // Issue one event, optionally strobing junk events while busy, then compare with the model
  task automatic do_event(input logic on, input logic [6:0] n, input logic [RW-1:0] r, input int junk);
    int guard, cnt, jsent, st0, exp_steal;
    logic [N-1:0] on_before;
    logic stable;
    guard = 0;
    while (!ready_out && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) check_val("ready_timeout", 1'b0, 1'b1);
    on_before = is_on_out; st0 = steal_seen;
    valid_in = 1'b1; is_note_on_in = on; note_in = n; rate_in = r;
    @(negedge clk);
    valid_in = 1'b0; cnt = 0; jsent = 0; stable = 1'b1;
    while (!ready_out && cnt < 50) begin
      cnt++;
      if (is_on_out !== on_before) stable = 1'b0;
      if (jsent < junk) begin
        valid_in = 1'b1; is_note_on_in = 1'($urandom); note_in = 7'($urandom); rate_in = RW'($urandom);
        jsent++;
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    #1;
    model_event(on, n, r, jsent, exp_steal);
    if (!(on && r == '0)) begin
      check_val("busy_cycles", cnt, N + 1);
      check_val("pre_commit_stable", stable, 1'b1);
    end
    check_val("steal_pulses", steal_seen - st0, exp_steal);
    check_outputs();
  endtask

  initial begin
    logic on;
    logic [6:0] n;
    logic [RW-1:0] r;
    rst_in = 1'b0; valid_in = 1'b0; is_note_on_in = 1'b0; note_in = 7'd0; rate_in = '0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_in = 1'b1;
    m_reset();

    // First note lands on voice 0
    do_event(1'b1, 7'd60, 24'd1000, 0);
    check_val("first_on", is_on_out, 4'b0001);
    check_val("first_rate", playback_rate_out[23:0], 24'd1000);

    // Fill, release 62, new note reuses voice 1
    do_event(1'b1, 7'd62, 24'd2000, 0);
    do_event(1'b1, 7'd64, 24'd3000, 0);
    do_event(1'b1, 7'd65, 24'd4000, 0);
    do_event(1'b0, 7'd62, 24'd0, 0);
    check_val("off62", is_on_out, 4'b1101);
    do_event(1'b1, 7'd67, 24'd2222, 0);
    check_val("v1_rate67", playback_rate_out[47:24], 24'd2222);
    check_val("all_on", is_on_out, 4'b1111);

    // All voices busy, new note
    apply_reset();
    do_event(1'b1, 7'd60, 24'd1000, 0);
    do_event(1'b1, 7'd62, 24'd2000, 0);
    do_event(1'b1, 7'd64, 24'd3000, 0);
    do_event(1'b1, 7'd65, 24'd4000, 0);
    do_event(1'b1, 7'd70, 24'd7777, 0);
`ifdef VOICE_ALLOC_STEAL_EN
    check_val("steal_v0_rate", playback_rate_out[23:0], 24'd7777);
    check_val("steal_drop", drop_count_out, 8'd0);
`else
    check_val("nosteal_v0_rate", playback_rate_out[23:0], 24'd1000);
    check_val("nosteal_drop", drop_count_out, 8'd1);
`endif

    // Retrigger of the same note
    apply_reset();
    do_event(1'b1, 7'd60, 24'd1000, 0);
    do_event(1'b1, 7'd60, 24'd500, 0);
    check_val("retrig_on", is_on_out, 4'b0001);
    check_val("retrig_rate", playback_rate_out[23:0], 24'd500);
    do_event(1'b1, 7'd61, 24'd0, 0);
    check_val("rate0_drop", drop_count_out, 8'd1);
    check_val("rate0_on", is_on_out, 4'b0001);

    // Busy strobes saturate the drop counter
    apply_reset();
    repeat (60) do_event(1'b0, 7'd100, 24'd0, 5);
    check_val("drop_sat", drop_count_out, 8'd255);

    // Reset asserted in the commit cycle
    apply_reset();
    do_event(1'b1, 7'd60, 24'd1000, 2);
    valid_in = 1'b1; is_note_on_in = 1'b1; note_in = 7'd62; rate_in = 24'd1234;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    check_val("in_commit", ready_out, 1'b0);
    rst_in = 1'b0;
    #1;
    check_reset_state();
    m_reset();
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
    do_event(1'b1, 7'd64, 24'd555, 0);
    check_val("post_rst_on", is_on_out, 4'b0001);
    check_val("post_rst_rate", playback_rate_out[23:0], 24'd555);

    // Random traffic against the model
    apply_reset();
    for (int t = 0; t < 200; t++) begin
      on = ($urandom_range(0, 9) < 7);
      n  = 7'(60 + $urandom_range(0, 7));
      r  = ($urandom_range(0, 9) == 0) ? 24'd0 : RW'($urandom_range(1, 16777215));
      do_event(on, n, r, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_OSCILLATORS, default 4: number of voices, range 2..16.
REQ-002 Parameter RATE_WIDTH, default 24: width of playback rate (cycles between samples).
REQ-003 clk_in  input  1  system clock, 100 MHz.
REQ-004 rst_in  input  1  one clock; reset is asynchronous and active-low.
REQ-005 valid_in  input  1  one-cycle event strobe from midi_processor.
REQ-006 is_note_on_in  input  1  1 = note-on, 0 = note-off; sampled with valid_in.
REQ-007 note_in  input  7  MIDI note number; sampled with valid_in.
REQ-008 rate_in  input  RATE_WIDTH  playback rate for note_in; sampled with valid_in.
REQ-009 ready_out  output  1  high when an event will be accepted.
REQ-010 is_on_out  output  NUM_OSCILLATORS  per-voice active flag to the oscillators.
REQ-011 playback_rate_out  output  NUM_OSCILLATORS x RATE_WIDTH  per-voice rate to the oscillators.
REQ-012 steal_out  output  1  one-cycle pulse when an active voice is reassigned.
REQ-013 drop_count_out  output  8  saturating count of rejected events.

Function
REQ-014 The FSM shall have the states IDLE, SCAN and COMMIT; ready_out shall be high only in IDLE.
REQ-015 IDLE with valid_in high shall latch note, rate and type, then enter SCAN on the next cycle.
REQ-016 valid_in while ready_out is low shall discard the event and increment drop_count_out, saturating at 255.
REQ-017 SCAN shall examine one voice per cycle, index 0 to NUM_OSCILLATORS-1, then enter COMMIT; an event takes NUM_OSCILLATORS+2 cycles from acceptance until ready_out is high again.
REQ-018 SCAN shall record three things: the first active voice whose stored note matches, the lowest-index inactive voice, and the active voice with the largest age.
REQ-019 For a note-on, the voice is chosen by the first rule that applies: matching active voice (retrigger), else lowest free voice, else the oldest voice (steal, see REQ-028).
REQ-020 On a note-on, COMMIT shall set is_on, the stored note and the playback rate of the chosen voice, and set that voice's age to 0.
REQ-021 Every voice whose age was below the chosen voice's old age shall increment its age; ages shall always remain a permutation of 0..NUM_OSCILLATORS-1.
REQ-022 Note-off with a matching active voice: COMMIT shall clear is_on for that voice only; its rate and age stay unchanged.
REQ-023 Note-off with no match shall make no change and shall not count as a drop.
REQ-024 Outputs shall update exactly at the COMMIT clock edge and are registered; steal_out shall be high for exactly that cycle when a steal occurs.
REQ-025 A note-on with rate_in = 0 shall be treated as a drop: no voice change, drop_count_out increments.

Reset
REQ-026 Asserting rst_in shall asynchronously force the following state, including mid-SCAN or mid-COMMIT, with no partial commit:
- state IDLE, ready_out 1
- is_on_out all 0, playback_rate_out all 0
- stored notes 0, age[i] = i
- steal_out 0, drop_count_out 0
REQ-027 After rst_in deasserts, the first event shall be accepted on the first rising edge at which rst_in is high.

Configuration
REQ-028 With VOICE_ALLOC_STEAL_EN defined, a note-on when all voices are active and none matches shall steal the oldest voice and pulse steal_out.
REQ-029 Without VOICE_ALLOC_STEAL_EN, that event shall be dropped and counted; steal_out shall be tied to 0.

Verification
REQ-030 Reset, then note-on 60 with rate 1000 -> voice 0 on with rate 1000 after 6 cycles (N=4); ready_out low for 5 cycles.
REQ-031 Note-ons 60, 62, 64, 65, then note-off 62 -> is_on_out = 4'b1101; then note-on 67 -> voice 1 takes note 67.
REQ-032 With STEAL_EN and all 4 voices busy (60, 62, 64, 65 in order), note-on 70 -> voice 0 reassigned and steal_out pulses once; without STEAL_EN -> no change and drop_count_out = 1.
REQ-033 Note-on 60 rate 1000, then note-on 60 rate 500 -> same voice retriggered with rate 500; no other voice turns on.
REQ-034 valid_in pulsed during SCAN -> event ignored and drop_count_out increments; 300 such events -> drop_count_out = 255.
REQ-035 rst_in asserted during COMMIT cycle -> all outputs reset values immediately, no voice left on.
